// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-master RAM arbiter.
package mem_arb_pkg;

  // Master command encodings (2'b11 is treated as no request)
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Owner / grant index
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  // A command is a request only when it is READ or WRITE.
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the CPU, loader and RAM sides of the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
);
  logic [1:0]    cpu_mem_cmd;
  logic [AW-1:0] cpu_mem_addr;
  logic [DW-1:0] cpu_w_data;
  logic [DW-1:0] cpu_r_data;
  logic          cpu_ack;

  logic [1:0]    ext_mem_cmd;
  logic [AW-1:0] ext_mem_addr;
  logic [DW-1:0] ext_w_data;
  logic [DW-1:0] ext_r_data;
  logic          ext_ack;

  logic [AW-1:0] ram_addr;
  logic          ram_write;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic          busy;
  logic          owner;

  // Arbiter side
  modport slave (
    input  cpu_mem_cmd, cpu_mem_addr, cpu_w_data,
    input  ext_mem_cmd, ext_mem_addr, ext_w_data,
    input  ram_dout,
    output cpu_r_data, cpu_ack, ext_r_data, ext_ack,
    output ram_addr, ram_write, ram_din, busy, owner
  );

  // Environment side: both masters plus the RAM
  modport master (
    output cpu_mem_cmd, cpu_mem_addr, cpu_w_data,
    output ext_mem_cmd, ext_mem_addr, ext_w_data,
    output ram_dout,
    input  cpu_r_data, cpu_ack, ext_r_data, ext_ack,
    input  ram_addr, ram_write, ram_din, busy, owner
  );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; the last-grant state lives in the caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  // Lone requester wins; on a tie the one not granted last wins
  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
    valid = |req;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the CPU and the loader through a 3-state FSM.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  logic [1:0]    state_q, state_d;
  logic [1:0]    cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          owner_q;
  logic          last_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] ext_rdata_q;

  logic [1:0]    req;
  logic          gnt;
  logic          gnt_valid;
  logic          grant;

  assign req   = {is_req(bus.ext_mem_cmd), is_req(bus.cpu_mem_cmd)};
  assign grant = (state_q == ST_IDLE) && gnt_valid;

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .last  (last_q),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  // Next-state: IDLE waits for a grant, ACCESS and RESP always advance
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gnt_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Latch the winner's request; inputs are ignored until the next IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_q   <= MNONE;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= OWN_CPU;
      last_q  <= 1'b1;
    end else if (grant) begin
      cmd_q   <= gnt ? bus.ext_mem_cmd  : bus.cpu_mem_cmd;
      addr_q  <= gnt ? bus.ext_mem_addr : bus.cpu_mem_addr;
      wdata_q <= gnt ? bus.ext_w_data   : bus.cpu_w_data;
      owner_q <= gnt;
      last_q  <= gnt;
    end
  end

  // Capture RAM read data for the owner at the end of RESP
  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else if (state_q == ST_RESP && cmd_q == MREAD) begin
      if (owner_q == OWN_EXT) ext_rdata_q <= bus.ram_dout;
      else                    cpu_rdata_q <= bus.ram_dout;
    end
  end

  // Write enable and acks are gated by reset so an aborted access has no effect
  assign bus.ram_addr   = addr_q;
  assign bus.ram_din    = wdata_q;
  assign bus.ram_write  = reset && (state_q == ST_ACCESS) && (cmd_q == MWRITE);
  assign bus.cpu_ack    = reset && (state_q == ST_RESP) && (owner_q == OWN_CPU);
  assign bus.ext_ack    = reset && (state_q == ST_RESP) && (owner_q == OWN_EXT);
  assign bus.cpu_r_data = cpu_rdata_q;
  assign bus.ext_r_data = ext_rdata_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.owner      = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected acks/writes, a monitor checks them.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic        who;
    logic        rd;
    logic [15:0] data;
    int          cyc;
  } ack_t;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   nchecks = 0;
  int   nerrors = 0;

  ack_t ack_q[$];
  wr_t  wr_q[$];
  logic [15:0] exp_cpu_r = 16'h0;
  logic [15:0] exp_ext_r = 16'h0;
  logic [15:0] mem [512];

  mem_arbiter_if #(.AW(9), .DW(16)) bus ();

  mem_arbiter #(.AW(9), .DW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment RAM: write on edge, read data valid the cycle after the address
  always @(posedge clk) begin
    if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every ack and RAM write against the scoreboard queues
  initial begin : monitor
    bit         pend = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 0;
        check("cpu_r_data", bus.cpu_r_data, exp_cpu_r);
        check("ext_r_data", bus.ext_r_data, exp_ext_r);
      end
      if (bus.ram_write) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", {23'd0, bus.ram_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", {23'd0, bus.ram_addr}, {23'd0, w.addr});
          check("wr_data", {16'd0, bus.ram_din}, {16'd0, w.data});
          check("wr_cycle", cyc, w.cyc);
        end
      end
      if (bus.cpu_ack || bus.ext_ack) begin
        if (ack_q.size() == 0) begin
          check("unexpected_ack", {30'd0, bus.ext_ack, bus.cpu_ack}, 32'd0);
        end else begin
          ack_t a;
          a = ack_q.pop_front();
          check("ack_which", {30'd0, bus.ext_ack, bus.cpu_ack},
                a.who ? 32'd2 : 32'd1);
          check("ack_owner", {31'd0, bus.owner}, {31'd0, a.who});
          check("ack_cycle", cyc, a.cyc);
          if (a.rd) begin
            if (a.who) exp_ext_r = a.data;
            else       exp_cpu_r = a.data;
            pend = 1;
          end
        end
      end
    end
  end

  task automatic drive(input logic who, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] data);
    if (who) begin
      bus.ext_mem_cmd  = cmd;
      bus.ext_mem_addr = addr;
      bus.ext_w_data   = data;
    end else begin
      bus.cpu_mem_cmd  = cmd;
      bus.cpu_mem_addr = addr;
      bus.cpu_w_data   = data;
    end
  endtask

  // Present a request, hold it until ack (bounded), drop it in the following cycle
  task automatic txn(input logic who, input logic [1:0] cmd, input logic [8:0] addr,
                     input logic [15:0] data);
    bit got = 0;
    drive(who, cmd, addr, data);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = who ? bus.ext_ack : bus.cpu_ack;
    end
    check(who ? "ext_ack_seen" : "cpu_ack_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    drive(who, MNONE, 9'h0, 16'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_cpu_r = 16'h0;
    exp_ext_r = 16'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    for (int i = 0; i < 512; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    drive(1'b0, MNONE, 9'h0, 16'h0);
    drive(1'b1, MNONE, 9'h0, 16'h0);
    bus.ram_dout = 16'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_owner", {31'd0, bus.owner}, 32'd0);
    check("rst_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
    check("rst_ext_ack", {31'd0, bus.ext_ack}, 32'd0);
    check("rst_ram_write", {31'd0, bus.ram_write}, 32'd0);
    check("rst_ram_addr", {23'd0, bus.ram_addr}, 32'd0);
    check("rst_ram_din", {16'd0, bus.ram_din}, 32'd0);
    check("rst_cpu_r_data", {16'd0, bus.cpu_r_data}, 32'd0);
    check("rst_ext_r_data", {16'd0, bus.ext_r_data}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // CPU write then read back
    @(posedge clk); #1;
    k = cyc;
    wr_q.push_back('{addr: 9'h005, data: 16'h1234, cyc: k + 1});
    ack_q.push_back('{who: 1'b0, rd: 1'b0, data: 16'h0, cyc: k + 2});
    txn(1'b0, MWRITE, 9'h005, 16'h1234);
    k = cyc;
    ack_q.push_back('{who: 1'b0, rd: 1'b1, data: 16'h1234, cyc: k + 2});
    txn(1'b0, MREAD, 9'h005, 16'h0);
    @(posedge clk); #1;

    // Simultaneous reads right after reset: CPU wins the first tie
    do_reset();
    k = cyc;
    ack_q.push_back('{who: 1'b0, rd: 1'b1, data: 16'h1234, cyc: k + 2});
    ack_q.push_back('{who: 1'b1, rd: 1'b1, data: 16'hA5A2, cyc: k + 5});
    fork
      txn(1'b0, MREAD, 9'h005, 16'h0);
      txn(1'b1, MREAD, 9'h007, 16'h0);
    join
    @(posedge clk); #1;

    // Both write continuously for 12 cycles: grants alternate
    k = cyc;
    wr_q.push_back('{addr: 9'h030, data: 16'h1111, cyc: k + 1});
    ack_q.push_back('{who: 1'b0, rd: 1'b0, data: 16'h0, cyc: k + 2});
    wr_q.push_back('{addr: 9'h031, data: 16'h2222, cyc: k + 4});
    ack_q.push_back('{who: 1'b1, rd: 1'b0, data: 16'h0, cyc: k + 5});
    wr_q.push_back('{addr: 9'h030, data: 16'h1111, cyc: k + 7});
    ack_q.push_back('{who: 1'b0, rd: 1'b0, data: 16'h0, cyc: k + 8});
    wr_q.push_back('{addr: 9'h031, data: 16'h2222, cyc: k + 10});
    ack_q.push_back('{who: 1'b1, rd: 1'b0, data: 16'h0, cyc: k + 11});
    drive(1'b0, MWRITE, 9'h030, 16'h1111);
    drive(1'b1, MWRITE, 9'h031, 16'h2222);
    repeat (12) @(posedge clk);
    #1;
    drive(1'b0, MNONE, 9'h0, 16'h0);
    drive(1'b1, MNONE, 9'h0, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Loader address changes during ACCESS: only the latched address reaches RAM
    k = cyc;
    wr_q.push_back('{addr: 9'h010, data: 16'hBEEF, cyc: k + 1});
    ack_q.push_back('{who: 1'b1, rd: 1'b0, data: 16'h0, cyc: k + 2});
    drive(1'b1, MWRITE, 9'h010, 16'hBEEF);
    @(posedge clk); #1;
    bus.ext_mem_addr = 9'h020;
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b1, MNONE, 9'h0, 16'h0);
    k = cyc;
    ack_q.push_back('{who: 1'b1, rd: 1'b1, data: 16'hBEEF, cyc: k + 2});
    txn(1'b1, MREAD, 9'h010, 16'h0);
    k = cyc;
    ack_q.push_back('{who: 1'b1, rd: 1'b1, data: 16'hA585, cyc: k + 2});
    txn(1'b1, MREAD, 9'h020, 16'h0);
    @(posedge clk); #1;

    // Reset during ACCESS of a write: no write, no ack, back to IDLE
    drive(1'b0, MWRITE, 9'h0AA, 16'hDEAD);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cpu_r = 16'h0;
    exp_ext_r = 16'h0;
    drive(1'b0, MNONE, 9'h0, 16'h0);
    @(negedge clk);
    check("abort_ram_write", {31'd0, bus.ram_write}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
    @(posedge clk); #1;
    k = cyc;
    ack_q.push_back('{who: 1'b0, rd: 1'b1, data: 16'hA50F, cyc: k + 2});
    txn(1'b0, MREAD, 9'h0AA, 16'h0);
    @(posedge clk); #1;

    // Command 11 is not a request
    drive(1'b0, 2'b11, 9'h001, 16'h5555);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("cmd11_busy", {31'd0, bus.busy}, 32'd0);
    end
    @(posedge clk); #1;
    drive(1'b0, MNONE, 9'h0, 16'h0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("ack_queue_empty", ack_q.size(), 32'd0);
    check("wr_queue_empty", wr_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single-port 512x16 RAM between the CPU and an external loader/debug port. Each master issues `mem_cmd`/`mem_addr`/`w_data` requests, held until a one-cycle acknowledge. The arbiter picks one master, runs the RAM access through a 3-state FSM, and returns registered read data. It sits between `cpu` plus loader and the RAM, and replaces the direct CPU-to-RAM connection.

## Interface
- `AW`, default 9: address width.
- `DW`, default 16: data width.
- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  synchronous, active-low reset.
- `cpu_mem_cmd`  in  2  CPU command: 00 NONE, 01 READ, 10 WRITE, 11 treated as NONE.
- `cpu_mem_addr`  in  AW  CPU address.
- `cpu_w_data`  in  DW  CPU write data.
- `cpu_r_data`  out  DW  CPU read data, registered.
- `cpu_ack`  out  1  one-cycle completion pulse to the CPU.
- `ext_mem_cmd`  in  2  loader command, same encoding as `cpu_mem_cmd`.
- `ext_mem_addr`  in  AW  loader address.
- `ext_w_data`  in  DW  loader write data.
- `ext_r_data`  out  DW  loader read data, registered.
- `ext_ack`  out  1  one-cycle completion pulse to the loader.
- `ram_addr`  out  AW  RAM address.
- `ram_write`  out  1  RAM write enable; the write commits on the clock edge.
- `ram_din`  out  DW  RAM write data.
- `ram_dout`  in  DW  RAM read data, valid the cycle after its address is presented.
- `busy`  out  1  FSM not in IDLE.
- `owner`  out  1  latched owner: 0 CPU, 1 loader.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - A request is any command of READ or WRITE.
  - If any request is present, latch the winner's cmd, addr and w_data, set `owner`, and go to ACCESS. Otherwise stay in IDLE.
- **Arbitration**
  - Only one master requesting: that master wins.
  - Both requesting: the master not granted last wins (round-robin).
  - The last-grant bit updates on every grant. It resets to 1, so the CPU wins the first tie.
- **ACCESS**
  - Drive `ram_addr` and `ram_din` from the latched values.
  - Assert `ram_write` only for a latched WRITE.
  - Always go to RESP.
- **RESP**
  - Pulse `ack` for the owner.
  - On a READ, capture `ram_dout` into the owner's `r_data` register.
  - Go to IDLE.
- `r_data` registers hold their value until that master's next READ. A WRITE never changes them.
- Requests are sampled only in IDLE. After latching, input changes from either master are ignored until the next IDLE.
- A master must deassert or change its command in the cycle after `ack`. Re-presenting a command in that cycle is a new transaction.
- `ram_write` is forced to 0 whenever `reset` is 0, so no write commits on a reset edge.
- Reset values:
  - FSM in IDLE.
  - `cpu_ack`, `ext_ack`, `ram_write`, `busy`, `owner` all 0.
  - `cpu_r_data`, `ext_r_data`, `ram_addr`, `ram_din` all 0.
  - Last-grant bit 1.

## Timing
- Request first sampled in IDLE at cycle T:
  - ACCESS at T+1: RAM address driven; a write commits at the T+1 edge.
  - RESP at T+2: `ack` high; read data is visible on `r_data` from T+3.
  - IDLE at T+3.
- Each transaction takes 3 cycles. Peak throughput is one transaction per 3 cycles.
- Worst-case wait for a master under contention is 6 cycles from request to `ack`.
- Reset asserted in ACCESS or RESP aborts the transaction. No `ack` is produced and there is no RAM write. The master must reissue the request.
- `busy` equals (state != IDLE), registered with the state.

## Structure
- Package `mem_arb_pkg` holds:
  - Command encodings MNONE, MREAD, MWRITE.
  - FSM state encoding.
  - Owner constants OWN_CPU and OWN_EXT.
- One sub-module, `rr_arb2`: inputs `req[1:0]` and `last`; outputs `gnt` and `valid`. It is purely combinational. The last-grant register stays in `mem_arbiter`.
- The datapath latches, the two `r_data` registers and the FSM all live in the top level.

## Test plan
- Reset, then CPU WRITE addr 0x005 data 0x1234 → `ram_write`=1 with `ram_addr`=0x005 at T+1; `cpu_ack` at T+2; `ext_ack` stays 0.
- CPU READ 0x005 after the above → `cpu_ack` at T+2; `cpu_r_data`=0x1234 from T+3; `ext_r_data` stays 0.
- Both masters READ in the same cycle right after reset → CPU served first (T+2), loader next (T+5); `owner` sequence 0 then 1.
- Both masters issue WRITE continuously for 12 cycles → grants alternate CPU, loader, CPU, loader; each gets `ack` every 6 cycles.
- Loader changes `ext_mem_addr` from 0x010 to 0x020 during ACCESS → RAM sees 0x010 only.
- `reset`=0 during ACCESS of a WRITE to 0x0AA → no `ram_write` pulse, no `ack`, FSM in IDLE next cycle, RAM[0x0AA] unchanged.
- `cpu_mem_cmd`=11 held → no grant, `busy` stays 0.
